// File: rtl/glitch_free_clkdiv_mux.sv
// Purpose: NUM_CH programmable clock dividers on clk; one is steered glitch-free onto registered clk_out.
// Latency: a switch drains within div_old+1 cycles and parks within 2*(div_new+1) cycles. Backpressure: sel_ready is low outside RUN and requests are not queued.
// Option GLITCH_FREE_CLKDIV_MUX_SYNC_RESTART_EN: one-cycle park that restarts the new channel at the start of its low phase.
module glitch_free_clkdiv_mux #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int SEL_W     = 2,
    parameter int RESET_SEL = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic                    clk_out,
    output logic                    clk_rise,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    switch_done,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_PARK  = 2'd2
    } state_t;

    localparam logic [SEL_W:0] LP_NUM_CH = (SEL_W + 1)'(NUM_CH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_cur;
    logic [SEL_W-1:0]  w_cur_nxt;
    logic [SEL_W-1:0]  r_new;
    logic [SEL_W-1:0]  w_new_nxt;
    logic              r_clk_out;
    logic              w_clk_out_nxt;
    logic              r_clk_rise;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [NUM_CH-1:0] w_ph;
    logic [NUM_CH-1:0] w_ph_nxt;
    logic [NUM_CH-1:0] w_fall;
    logic              w_ph_cur;
    logic              w_ph_nxt_cur;
    logic              w_fall_cur;
    logic              w_fall_new;
    logic              w_restart;

`ifdef GLITCH_FREE_CLKDIV_MUX_SYNC_RESTART_EN
    assign w_restart = (r_state == S_PARK);
`else
    assign w_restart = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic             r_ph;
        logic             w_hit;
        logic             w_force;

        // >= rather than == so a lowered divide ends the half-period at once instead of wrapping
        assign w_hit       = (r_cnt >= div_cfg[g*DIV_W +: DIV_W]);
        assign w_force     = w_restart && (r_new == SEL_W'(g));
        assign w_ph[g]     = r_ph;
        assign w_ph_nxt[g] = w_force ? 1'b0 : (r_ph ^ w_hit);
        assign w_fall[g]   = w_hit & r_ph;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_ph  <= 1'b0;
            end else if (w_force) begin
                r_cnt <= '0;
                r_ph  <= 1'b0;
            end else if (w_hit) begin
                r_cnt <= '0;
                r_ph  <= ~r_ph;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_ph_cur     = 1'b0;
        w_ph_nxt_cur = 1'b0;
        w_fall_cur   = 1'b0;
        w_fall_new   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur == SEL_W'(i)) begin
                w_ph_cur     = w_ph[i];
                w_ph_nxt_cur = w_ph_nxt[i];
                w_fall_cur   = w_fall[i];
            end
            if (r_new == SEL_W'(i)) begin
                w_fall_new = w_fall[i];
            end
        end
    end

    // clk_out is registered from the next-state phase so it stays cycle-aligned with ph[cur]
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_new_nxt     = r_new;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_clk_out_nxt = w_ph_nxt_cur;
        case (r_state)
            S_RUN: begin
                if (sel_valid) begin
                    if ({1'b0, sel} >= LP_NUM_CH) begin
                        w_err_nxt = 1'b1;
                    end else if (sel != r_cur) begin
                        w_new_nxt = sel;
                        // a high phase ending this very cycle needs no drain
                        if (w_ph_cur && !w_fall_cur) begin
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_state_nxt   = S_PARK;
                            w_clk_out_nxt = 1'b0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (w_fall_cur) begin
                    w_state_nxt = S_PARK;
                end
            end
            S_PARK: begin
                w_clk_out_nxt = 1'b0;
                if (w_restart || w_fall_new) begin
                    w_state_nxt = S_RUN;
                    w_cur_nxt   = r_new;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_cur      <= SEL_W'(RESET_SEL);
            r_new      <= SEL_W'(RESET_SEL);
            r_clk_out  <= 1'b0;
            r_clk_rise <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_new      <= w_new_nxt;
            r_clk_out  <= w_clk_out_nxt;
            r_clk_rise <= w_clk_out_nxt & ~r_clk_out;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign sel_ready   = (r_state == S_RUN);
    assign clk_out     = r_clk_out;
    assign clk_rise    = r_clk_rise;
    assign cur_sel     = r_cur;
    assign switch_done = r_done;
    assign sel_err     = r_err;

endmodule

// File: tb/tb_glitch_free_clkdiv_mux.sv
// Randomized and directed bench for glitch_free_clkdiv_mux (NUM_CH=4, DIV_W=8, SEL_W=3, divides {3,2,1,0}).
// The model derives each channel phase arithmetically from elapsed cycles and applies the switch rules per cycle.
module tb_glitch_free_clkdiv_mux;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int SEL_W  = 3;
`ifdef GLITCH_FREE_CLKDIV_MUX_SYNC_RESTART_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_cfg = {8'd3, 8'd2, 8'd1, 8'd0};
    logic [SEL_W-1:0]        sel = '0;
    logic                    sel_valid = 1'b0;
    logic                    sel_ready;
    logic                    clk_out;
    logic                    clk_rise;
    logic [SEL_W-1:0]        cur_sel;
    logic                    switch_done;
    logic                    sel_err;

    glitch_free_clkdiv_mux #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SEL_W(SEL_W), .RESET_SEL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .div_cfg(div_cfg), .sel(sel), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .clk_out(clk_out), .clk_rise(clk_rise), .cur_sel(cur_sel),
        .switch_done(switch_done), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // model state: t = edges since reset release, off[c] = edge at which channel c last (re)started
    int t;
    int off [NUM_CH];
    int m_state;          // 0 run, 1 drain, 2 park
    int m_cur;
    int m_new;
    bit m_clk, m_rise, m_done, m_err;
    int lowrun, hirun, last_low, last_high;

    // channel c divides by c, so its half-period is c+1 cycles
    function automatic int ph(input int c, input int tt);
        return ((tt - off[c]) / (c + 1)) % 2;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {clk_out, clk_rise, sel_ready, switch_done, sel_err, cur_sel};
    endfunction

    function automatic logic [7:0] mdl_vec();
        return {m_clk, m_rise, (m_state == 0), m_done, m_err, 3'(m_cur)};
    endfunction

    task automatic model_reset();
        t = 0;
        for (int c = 0; c < NUM_CH; c++) off[c] = 0;
        m_state = 0; m_cur = 0; m_new = 0;
        m_clk = 0; m_rise = 0; m_done = 0; m_err = 0;
        lowrun = 1; hirun = 0; last_low = 0; last_high = 0;
    endtask

    // advance model by one edge using the inputs currently driven, then clock the DUT
    task automatic step();
        bit n_clk;
        bit acc;
        n_clk  = m_clk;
        m_done = 0;
        m_err  = 0;
        acc    = (m_state == 0) && sel_valid;
        case (m_state)
            0: begin
                n_clk = bit'(ph(m_cur, t + 1));
                if (acc) begin
                    if (int'(sel) >= NUM_CH) begin
                        m_err = 1;
                    end else if (int'(sel) != m_cur) begin
                        m_new = int'(sel);
                        if (ph(m_cur, t) == 1 && ph(m_cur, t + 1) == 1) begin
                            m_state = 1;
                        end else begin
                            m_state = 2;
                            n_clk   = 0;
                        end
                    end
                end
            end
            1: begin
                n_clk = bit'(ph(m_cur, t + 1));
                if (n_clk == 0) m_state = 2;
            end
            default: begin
                n_clk = 0;
                if (SYNC) begin
                    off[m_new] = t + 1;
                    m_state = 0; m_cur = m_new; m_done = 1;
                end else if (ph(m_new, t) == 1 && ph(m_new, t + 1) == 0) begin
                    m_state = 0; m_cur = m_new; m_done = 1;
                end
            end
        endcase
        m_rise = n_clk & ~m_clk;
        m_clk  = n_clk;
        @(posedge clk);
        #1;
        t++;
        if (clk_out === 1'b1) begin
            if (lowrun > 0) last_low = lowrun;
            lowrun = 0;
            hirun++;
        end else begin
            if (hirun > 0) last_high = hirun;
            hirun = 0;
            lowrun++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel_valid = 1'b0; sel = '0;
        #3;
        n_vec++;
        if (dut_vec() !== 8'b0010_0000) begin
            n_bad++; $display("FAIL reset_values dut=%b exp=%b", dut_vec(), 8'b0010_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL reset_run t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
            n_vec++;
            if (clk_out !== 1'((i + 1) % 2)) begin
                n_bad++; $display("FAIL ch0_toggle t=%0d clk_out=%b exp=%0d", t, clk_out, (i + 1) % 2);
            end
        end
    endtask

    task automatic test_switch_0_to_3();
        int phase = 0, dones = 0, gap = 0, hi = 0;
        sel = 3'd3; sel_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            sel_valid = 1'b0;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL sw03 t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
            if (switch_done) dones++;
            if (phase == 0 && switch_done) phase = 1;
            else if (phase == 1 && clk_rise) begin gap = last_low; phase = 2; end
            else if (phase == 2 && !clk_out) begin hi = last_high; phase = 3; end
        end
        n_vec++;
        if (phase != 3) begin
            n_bad++; $display("FAIL sw03_timeout phase=%0d exp=3", phase);
        end else begin
            n_vec++;
            if (gap < 4) begin n_bad++; $display("FAIL sw03_gap got=%0d exp>=4", gap); end
            n_vec++;
            if (hi != 4) begin n_bad++; $display("FAIL sw03_high got=%0d exp=4", hi); end
        end
        n_vec++;
        if (dones != 1 || cur_sel !== 3'd3) begin
            n_bad++; $display("FAIL sw03_done dones=%0d cur=%0d exp 1 and 3", dones, cur_sel);
        end
    endtask

    task automatic test_mid_high_3_to_1();
        int phase = 0, old_hi = 0, gap = 0, hi = 0;
        bit armed = 0;
        for (int i = 0; i < 60; i++) begin
            if (!armed && phase == 0 && clk_rise === 1'b1) begin
                sel = 3'd1; sel_valid = 1'b1; armed = 1;
            end
            step();
            sel_valid = 1'b0;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL sw31 t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
            if (armed) begin
                if (phase == 0 && !clk_out) begin old_hi = last_high; phase = 1; end
                else if (phase == 1 && switch_done) phase = 2;
                else if (phase == 2 && clk_rise) begin gap = last_low; phase = 3; end
                else if (phase == 3 && !clk_out) begin hi = last_high; phase = 4; end
            end
        end
        n_vec++;
        if (phase != 4) begin
            n_bad++; $display("FAIL sw31_timeout phase=%0d exp=4", phase);
        end else begin
            n_vec++;
            if (old_hi != 4) begin n_bad++; $display("FAIL sw31_drain_high got=%0d exp=4", old_hi); end
            n_vec++;
            if (gap < 2) begin n_bad++; $display("FAIL sw31_gap got=%0d exp>=2", gap); end
            n_vec++;
            if (hi != 2) begin n_bad++; $display("FAIL sw31_new_high got=%0d exp=2", hi); end
        end
    endtask

    task automatic test_ignored_requests();
        int busy = 0, dones = 0;
        sel = 3'd2; sel_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (m_state != 0) begin
                sel = 3'd0; sel_valid = 1'b1;
                busy++;
            end else begin
                sel_valid = 1'b0;
            end
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL ignore t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (busy == 0 || cur_sel !== 3'd2) begin
            n_bad++; $display("FAIL ignore_result busy=%0d cur=%0d exp busy>0 cur=2", busy, cur_sel);
        end
        sel = 3'd2; sel_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            sel_valid = 1'b0;
            if (switch_done) dones++;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL same_sel t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (dones != 0 || cur_sel !== 3'd2) begin
            n_bad++; $display("FAIL same_sel_result dones=%0d cur=%0d exp 0 and 2", dones, cur_sel);
        end
    endtask

    task automatic test_sel_err();
        sel = 3'd5; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        n_vec++;
        if (sel_err !== 1'b1 || cur_sel !== 3'd2 || dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL sel_err_pulse err=%b cur=%0d dut=%b model=%b", sel_err, cur_sel, dut_vec(), mdl_vec());
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (sel_err !== 1'b0 || dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL sel_err_after t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_switch_0_to_2();
        int phase = 0, gap = 0, hi = 0, gmin, gmax;
        bit armed = 0;
        sel = 3'd0; sel_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            sel_valid = 1'b0;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL to_ch0 t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
        end
        gmin = SYNC ? 4 : 1;
        gmax = SYNC ? 4 : 1000;
        for (int i = 0; i < 40; i++) begin
            if (!armed && clk_out === 1'b1 && sel_ready === 1'b1) begin
                sel = 3'd2; sel_valid = 1'b1; armed = 1;
            end
            step();
            sel_valid = 1'b0;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL sw02 t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
            if (armed) begin
                if (phase == 0 && switch_done) phase = 1;
                else if (phase == 1 && clk_rise) begin gap = last_low; phase = 2; end
                else if (phase == 2 && !clk_out) begin hi = last_high; phase = 3; end
            end
        end
        n_vec++;
        if (phase != 3) begin
            n_bad++; $display("FAIL sw02_timeout phase=%0d exp=3", phase);
        end else begin
            n_vec++;
            if (gap < gmin || gap > gmax) begin
                n_bad++; $display("FAIL sw02_gap got=%0d exp=%0d..%0d", gap, gmin, gmax);
            end
            n_vec++;
            if (hi != 3) begin n_bad++; $display("FAIL sw02_high got=%0d exp=3", hi); end
        end
    endtask

    task automatic test_reset_mid_switch();
        bit parked = 0;
        sel = 3'd3; sel_valid = 1'b1;
        for (int i = 0; i < 20 && !parked; i++) begin
            step();
            sel_valid = 1'b0;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL to_park t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
            if (m_state == 2) parked = 1;
        end
        n_vec++;
        if (!parked) begin
            n_bad++; $display("FAIL park_timeout parked=%0d exp=1", parked);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== 8'b0010_0000) begin
            n_bad++; $display("FAIL reset_in_park dut=%b exp=%b", dut_vec(), 8'b0010_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL after_reset t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            sel_valid = ($urandom_range(0, 3) == 0);
            sel       = 3'($urandom_range(0, 7));
            step();
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++; $display("FAIL random t=%0d dut=%b model=%b", t, dut_vec(), mdl_vec());
            end
        end
        sel_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_switch_0_to_3();
        test_mid_high_3_to_1();
        test_ignored_requests();
        test_sel_err();
        test_switch_0_to_2();
        test_reset_mid_switch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d exp=finished", t);
        $fatal(1, "watchdog expired");
    end

endmodule
